// File: rtl/time_display_driver.sv
// Six-digit multiplexed 7-segment driver for HH MM SS with 12/24 h presentation.
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero hours-tens digit.
module time_display_driver #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {UNPRIMED, RUNNING} state_t;

  state_t          state;
  logic [RC_W-1:0] rc;
  logic [2:0]      di;
  logic [5:0]      s_q;
  logic [5:0]      m_q;
  logic [4:0]      h_q;
  logic            mode_q;

  logic            tc;
  logic            h_valid;
  logic            m_valid;
  logic            s_valid;
  logic            pm;
  logic [4:0]      h_disp;
  logic [7:0]      h_bcd;
  logic [7:0]      m_bcd;
  logic [7:0]      s_bcd;
  logic [6:0]      seg_next;

  // Compare-subtract conversion; valid for v <= 59, returns {tens, units}.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] r;
    logic [3:0] t;
    if      (v >= 6'd50) begin t = 4'd5; r = v - 6'd50; end
    else if (v >= 6'd40) begin t = 4'd4; r = v - 6'd40; end
    else if (v >= 6'd30) begin t = 4'd3; r = v - 6'd30; end
    else if (v >= 6'd20) begin t = 4'd2; r = v - 6'd20; end
    else if (v >= 6'd10) begin t = 4'd1; r = v - 6'd10; end
    else                 begin t = 4'd0; r = v;         end
    return {t, r[3:0]};
  endfunction

  function automatic logic [6:0] font(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  assign tc = (rc == RC_W'(REFRESH_DIV - 1));

  always_comb begin
    h_valid = (h_q <= 5'd23);
    m_valid = (m_q <= 6'd59);
    s_valid = (s_q <= 6'd59);
    pm      = h_valid && (h_q >= 5'd12);
    h_disp  = h_q;
    if (mode_q) begin
      if (h_q == 5'd0)       h_disp = 5'd12;
      else if (h_q > 5'd12)  h_disp = h_q - 5'd12;
    end
    h_bcd = to_bcd({1'b0, h_disp});
    m_bcd = to_bcd(m_q);
    s_bcd = to_bcd(s_q);

    seg_next = SEG_BLANK;
    case (di)
      3'd0: begin
        if (!h_valid) seg_next = SEG_DASH;
`ifdef LEADING_ZERO_BLANK_EN
        else if (h_bcd[7:4] == 4'd0) seg_next = SEG_BLANK;
`endif
        else seg_next = font(h_bcd[7:4]);
      end
      3'd1:    seg_next = h_valid ? font(h_bcd[3:0]) : SEG_DASH;
      3'd2:    seg_next = m_valid ? font(m_bcd[7:4]) : SEG_DASH;
      3'd3:    seg_next = m_valid ? font(m_bcd[3:0]) : SEG_DASH;
      3'd4:    seg_next = s_valid ? font(s_bcd[7:4]) : SEG_DASH;
      3'd5:    seg_next = s_valid ? font(s_bcd[3:0]) : SEG_DASH;
      default: seg_next = SEG_BLANK;
    endcase
  end

  // The unprimed cycle only captures the snapshot; counters hold so digit 0
  // still gets its full REFRESH_DIV cycles once outputs go live.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= UNPRIMED;
      rc     <= '0;
      di     <= '0;
      s_q    <= '0;
      m_q    <= '0;
      h_q    <= '0;
      mode_q <= 1'b0;
      an     <= '1;
      seg    <= '1;
      dp     <= 1'b1;
    end else begin
      case (state)
        UNPRIMED: begin
          s_q    <= seconds;
          m_q    <= minutes;
          h_q    <= hours;
          mode_q <= mode;
          state  <= RUNNING;
          an     <= '1;
          seg    <= '1;
          dp     <= 1'b1;
        end
        RUNNING: begin
          an  <= ~(6'b100000 >> di);
          seg <= seg_next;
          dp  <= ~((di == 3'd5) && mode_q && pm);
          if (tc) begin
            rc <= '0;
            if (di == 3'd5) begin
              di     <= '0;
              s_q    <= seconds;
              m_q    <= minutes;
              h_q    <= hours;
              mode_q <= mode;
            end else begin
              di <= di + 3'd1;
            end
          end else begin
            rc <= rc + RC_W'(1);
          end
        end
        default: state <= UNPRIMED;
      endcase
    end
  end

endmodule

// File: doc/time_display_driver.md
# time_display_driver

Multiplexed six-digit 7-segment driver consuming the binary `seconds`/`minutes`/`hours` outputs of the digital clock counter and rendering HH MM SS on a common-anode display. Sits between the 1 Hz time-keeping counter and the board display pins. Runs on the fast system clock. Performs these steps:
- snapshots the time once per scan, so digits never tear;
- converts binary to BCD;
- applies 12-hour presentation;
- scans one digit at a time.

## Interface
- `REFRESH_DIV`, 100000: system-clock cycles each digit stays enabled; legal range ≥1.
- `clk` input 1: system clock; all state on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `mode` input 1: 0 = 24 h presentation, 1 = 12 h presentation.
- `seconds` input 6: binary seconds, valid 0–59.
- `minutes` input 6: binary minutes, valid 0–59.
- `hours` input 5: binary hours, valid 0–23.
- `an` output 6: digit enables, active-low; `an[5]` = hours tens … `an[0]` = seconds units.
- `seg` output 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp` output 1: decimal point, active-low.

## Operation
- Refresh counter `rc` counts 0..REFRESH_DIV-1, then wraps. Terminal count (TC) = `rc == REFRESH_DIV-1`.
- Digit index `di` counts 0..5. It advances on TC and wraps 5→0. Digit `di` drives `an[5-di]`.
- Snapshot registers `{s_q, m_q, h_q, mode_q}` load from the inputs:
  - on the first clock after reset deassertion;
  - on every TC where `di == 5` (start of a new scan).
  - They are stable for the whole scan.
- Hours presentation, from `h_q`:
  - 24 h mode: displayed value = `h_q`.
  - 12 h mode: 0 → 12; 1–12 unchanged; 13–23 → `h_q` − 12. PM = (`h_q` ≥ 12).
- Invalid input: `h_q` > 23, or `m_q`/`s_q` > 59.
  - The affected pair shows dash-dash, g only: `seg = 7'b0111111`.
  - An invalid `h_q` also suppresses PM.
- BCD: tens = v/10, units = v%10, for v ≤ 59. Combinational, no multiplier. Compare-subtract or constant-divide logic is acceptable.
- Segment codes, active-low, gfedcba:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - blank = 1111111
- `dp` is lit (0) only when `di == 5`, `mode_q == 1`, and PM. Otherwise `dp = 1`.
- `mode` changing mid-scan has no visible effect until the next snapshot.

## Timing
- `an`, `seg`, `dp` are registered. They reflect `di` and the snapshot from the previous cycle (1-cycle decode latency).
- Reset values: `rc`=0, `di`=0, snapshot=0, `an`=6'b111111, `seg`=7'b1111111, `dp`=1.
- First clock after reset release:
  - the snapshot loads;
  - outputs stay blank, because outputs are decoded from the pre-load snapshot state and the block is gated off while unprimed.
- Second clock after reset release: digit 0 (`an`=6'b011111) is driven with the captured value.
- Each digit is active for exactly REFRESH_DIV cycles. One full scan = 6·REFRESH_DIV cycles.
- A reset assertion mid-scan forces reset values immediately (asynchronous), with no partial digit.
- REFRESH_DIV=1: `di` advances every cycle and a snapshot occurs every 6 cycles.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - hours tens digit shows blank when its BCD value is 0 (e.g. 09 → " 9");
  - 12 h 10–12 and all 24 h values ≥10 are unaffected;
  - dashes are unaffected.
- Undefined: the hours tens digit always shows its numeral, including 0.

## Test plan
- Reset, then REFRESH_DIV=4, mode=0, time 13:45:07 → `an` sequence 011111/101111/110111/111011/111101/111110, 4 cycles each. `seg` = 1111001, 0110000, 0011001, 0010010, 1000000, 1111000. `dp` = 1 throughout.
- mode=1, hours=0, then hours=13 and 12 → hour digits show 1,2 / 0,1 / 1,2. `dp` = 0 on `di == 5` for hours 13 and 12; `dp` = 1 for hours 0.
- Change `seconds` 07→08 mid-scan at `di == 2` → the current scan still shows 07. The next scan (after the `di == 5` TC) shows 08.
- hours=25, minutes=60, seconds=30 → hour and minute pairs are 0111111. Seconds show 3,0. `dp` = 1 even in mode=1.
- Assert `reset` for 1 cycle at `di == 3` → `an`=111111, `seg`=1111111, `dp`=1 immediately. Digit 0 is driven on the 2nd clock after release.
- With `LEADING_ZERO_BLANK_EN`, hours=9, mode=0 → `di == 0` gives `seg`=1111111 and `di == 1` gives 0010000. Without the macro, `di == 0` gives 1000000.
